// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for an in-order pipeline with a multi-cycle multiplier.
// Tracks in-flight multiplies per destination register, selects the EX
// operand forwarding source, and raises the decode stall for load-use,
// mul-use, pending-result, write-after-write and multiplier-full hazards.
module hazard_scoreboard #(
  parameter int NSRC    = 2,
  parameter int REG_W   = 5,
  parameter int MAX_OUT = 4,
  parameter int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NSRC*REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]        id_rd,
  input  logic                    id_we,
  input  logic                    id_is_mul,
  input  logic                    ex_valid,
  input  logic                    ex_we,
  input  logic                    ex_is_load,
  input  logic                    ex_is_mul,
  input  logic [NSRC*REG_W-1:0]   ex_rs,
  input  logic [REG_W-1:0]        ex_rd,
  input  logic                    mem_valid,
  input  logic                    mem_we,
  input  logic                    mem_is_load,
  input  logic [REG_W-1:0]        mem_rd,
  input  logic                    wb_valid,
  input  logic                    wb_we,
  input  logic [REG_W-1:0]        wb_rd,
  input  logic                    mul_done_valid,
  input  logic [REG_W-1:0]        mul_done_rd,
  input  logic                    flush,
  output logic [2*NSRC-1:0]       fwd_sel,
  output logic                    stall,
  output logic [(2**REG_W)-1:0]   pend_vec,
  output logic [OW-1:0]           out_cnt,
  output logic [31:0]             perf_stall_cnt
);

  localparam int NREG = 2**REG_W;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUT);

  logic [NREG-1:0]  pendVec;
  logic [NREG-1:0]  pendNext;
  logic [OW-1:0]    outCnt;
  logic [OW-1:0]    cntNext;
  logic             mulqValid;
  logic [REG_W-1:0] mulqRd;
  logic [31:0]      perfStallCnt;
  logic             mulIssue;
  logic             mulDone;
  logic [2*NSRC-1:0] fwdSel;
  logic             srcHazard;
  logic             wawHazard;
  logic             fullHazard;
  logic             stallInt;
  logic [REG_W-1:0] idSrc [NSRC];
  logic [REG_W-1:0] exSrc [NSRC];

  // Unpack the per-source register indices of the decode and EX instructions.
  for (genvar g = 0; g < NSRC; g++) begin : gUnpack
    assign idSrc[g] = id_rs[g*REG_W +: REG_W];
    assign exSrc[g] = ex_rs[g*REG_W +: REG_W];
  end

  // Register 0 is hardwired, so multiplies to it never enter the scoreboard.
  assign mulIssue = ex_valid & ex_is_mul & ex_we & (ex_rd != '0) & ~flush;
  assign mulDone  = mul_done_valid & (mul_done_rd != '0);

  // Next pending vector: completion clears first so a same-register issue wins.
  always_comb begin
    pendNext = pendVec;
    if (mulDone) pendNext[mul_done_rd] = 1'b0;
    if (mulIssue) pendNext[ex_rd] = 1'b1;
  end

  // Next in-flight count, saturating at both ends; issue plus done cancels.
  always_comb begin
    cntNext = outCnt;
    if (mulIssue && !mulDone) begin
      if (outCnt != MAX_CNT) cntNext = outCnt + 1'b1;
    end else if (mulDone && !mulIssue) begin
      if (outCnt != '0) cntNext = outCnt - 1'b1;
    end
  end

  // Operand forwarding for each EX source: MEM, then delayed MUL, then WB.
  always_comb begin
    fwdSel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (exSrc[i] != '0) begin
        if (mem_valid && mem_we && !mem_is_load && (mem_rd == exSrc[i])) begin
          fwdSel[2*i +: 2] = 2'd1;
        end else if (mulqValid && (mulqRd == exSrc[i])) begin
          fwdSel[2*i +: 2] = 2'd3;
        end else if (wb_valid && wb_we && (wb_rd == exSrc[i])) begin
          fwdSel[2*i +: 2] = 2'd2;
        end
      end
    end
  end

  // Decode stall: any source hazard, a WAW on the destination, or a full multiplier.
  always_comb begin
    srcHazard = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (idSrc[i] != '0) begin
        if (ex_valid && ex_we && ex_is_load && (ex_rd == idSrc[i])) srcHazard = 1'b1;
        if (ex_valid && ex_we && ex_is_mul && !flush && (ex_rd == idSrc[i])) srcHazard = 1'b1;
        if (pendVec[idSrc[i]] && !(mul_done_valid && (mul_done_rd == idSrc[i]))) srcHazard = 1'b1;
      end
    end
    wawHazard  = id_we && (id_rd != '0) && (pendVec[id_rd] || (mulIssue && (ex_rd == id_rd)));
    fullHazard = id_is_mul && (outCnt == MAX_CNT) && !mul_done_valid;
    stallInt   = id_valid && (srcHazard || wawHazard || fullHazard);
  end

  // Scoreboard state, completion delay slot and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pendVec      <= '0;
      outCnt       <= '0;
      mulqValid    <= 1'b0;
      mulqRd       <= '0;
      perfStallCnt <= '0;
    end else begin
      pendVec   <= pendNext;
      outCnt    <= cntNext;
      mulqValid <= mul_done_valid;
      mulqRd    <= mul_done_rd;
      if (stallInt && (perfStallCnt != 32'hFFFF_FFFF)) perfStallCnt <= perfStallCnt + 32'd1;
    end
  end

  assign fwd_sel        = fwdSel;
  assign stall          = stallInt;
  assign pend_vec       = pendVec;
  assign out_cnt        = outCnt;
  assign perf_stall_cnt = perfStallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of combinational hazard and
// forwarding vectors, then hand-written multi-cycle sequences for the
// scoreboard, full multiplier, flush, reset and counter saturation.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       idValid;
    logic       idWe;
    logic       idIsMul;
    logic [9:0] idRs;
    logic [4:0] idRd;
    logic       exValid;
    logic       exWe;
    logic       exIsLoad;
    logic       exIsMul;
    logic [9:0] exRs;
    logic [4:0] exRd;
    logic       flush;
    logic       memValid;
    logic       memWe;
    logic       memIsLoad;
    logic [4:0] memRd;
    logic       wbValid;
    logic       wbWe;
    logic [4:0] wbRd;
    logic [3:0] expFwd;
    logic       expStall;
  } vec_t;

  localparam int NVEC = 20;

  logic        clk;
  logic        rstN;
  logic        idValid, idWe, idIsMul;
  logic [9:0]  idRs;
  logic [4:0]  idRd;
  logic        exValid, exWe, exIsLoad, exIsMul;
  logic [9:0]  exRs;
  logic [4:0]  exRd;
  logic        memValid, memWe, memIsLoad;
  logic [4:0]  memRd;
  logic        wbValid, wbWe;
  logic [4:0]  wbRd;
  logic        mulDoneValid;
  logic [4:0]  mulDoneRd;
  logic        flush;
  logic [3:0]  fwdSel;
  logic        stall;
  logic [31:0] pendVec;
  logic [2:0]  outCnt;
  logic [31:0] perfStallCnt;

  int numChecks;
  int numFails;
  vec_t vecs [NVEC];

  hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rstN),
    .id_valid       (idValid),
    .id_rs          (idRs),
    .id_rd          (idRd),
    .id_we          (idWe),
    .id_is_mul      (idIsMul),
    .ex_valid       (exValid),
    .ex_we          (exWe),
    .ex_is_load     (exIsLoad),
    .ex_is_mul      (exIsMul),
    .ex_rs          (exRs),
    .ex_rd          (exRd),
    .mem_valid      (memValid),
    .mem_we         (memWe),
    .mem_is_load    (memIsLoad),
    .mem_rd         (memRd),
    .wb_valid       (wbValid),
    .wb_we          (wbWe),
    .wb_rd          (wbRd),
    .mul_done_valid (mulDoneValid),
    .mul_done_rd    (mulDoneRd),
    .flush          (flush),
    .fwd_sel        (fwdSel),
    .stall          (stall),
    .pend_vec       (pendVec),
    .out_cnt        (outCnt),
    .perf_stall_cnt (perfStallCnt)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack two source indices: a is source 0 (low bits), b is source 1.
  function automatic logic [9:0] rs(input logic [4:0] a, input logic [4:0] b);
    return {b, a};
  endfunction

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive every stage input to idle.
  task automatic clearInputs();
    idValid = 0; idWe = 0; idIsMul = 0; idRs = '0; idRd = '0;
    exValid = 0; exWe = 0; exIsLoad = 0; exIsMul = 0; exRs = '0; exRd = '0;
    memValid = 0; memWe = 0; memIsLoad = 0; memRd = '0;
    wbValid = 0; wbWe = 0; wbRd = '0;
    mulDoneValid = 0; mulDoneRd = '0; flush = 0;
  endtask

  // Drive the pipeline-stage inputs from one table record.
  task automatic applyStimulus(input vec_t v);
    idValid = v.idValid; idWe = v.idWe; idIsMul = v.idIsMul; idRs = v.idRs; idRd = v.idRd;
    exValid = v.exValid; exWe = v.exWe; exIsLoad = v.exIsLoad; exIsMul = v.exIsMul;
    exRs = v.exRs; exRd = v.exRd; flush = v.flush;
    memValid = v.memValid; memWe = v.memWe; memIsLoad = v.memIsLoad; memRd = v.memRd;
    wbValid = v.wbValid; wbWe = v.wbWe; wbRd = v.wbRd;
    mulDoneValid = 0; mulDoneRd = '0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Build the combinational vector table; scoreboard state is empty for all of them.
  task automatic buildTable();
    for (int i = 0; i < NVEC; i++) vecs[i] = '0;
    // 1..4: load-use on either source, masked by id_valid and by x0
    vecs[1].exValid = 1; vecs[1].exWe = 1; vecs[1].exIsLoad = 1; vecs[1].exRd = 5;
    vecs[1].idValid = 1; vecs[1].idRs = rs(5, 7); vecs[1].idRd = 6; vecs[1].idWe = 1; vecs[1].expStall = 1;
    vecs[2] = vecs[1]; vecs[2].idRs = rs(7, 5);
    vecs[3] = vecs[1]; vecs[3].idValid = 0; vecs[3].expStall = 0;
    vecs[4] = vecs[1]; vecs[4].exRd = 0; vecs[4].idRs = rs(0, 0); vecs[4].expStall = 0;
    // 5..6: mul-use, suppressed by flush
    vecs[5].exValid = 1; vecs[5].exWe = 1; vecs[5].exIsMul = 1; vecs[5].exRd = 8;
    vecs[5].idValid = 1; vecs[5].idRs = rs(1, 8); vecs[5].idRd = 2; vecs[5].idWe = 1; vecs[5].expStall = 1;
    vecs[6] = vecs[5]; vecs[6].flush = 1; vecs[6].expStall = 0;
    // 7..9: WAW against an EX multiply
    vecs[7].exValid = 1; vecs[7].exWe = 1; vecs[7].exIsMul = 1; vecs[7].exRd = 4;
    vecs[7].idValid = 1; vecs[7].idRs = rs(1, 0); vecs[7].idRd = 4; vecs[7].idWe = 1; vecs[7].expStall = 1;
    vecs[8] = vecs[7]; vecs[8].flush = 1; vecs[8].expStall = 0;
    vecs[9] = vecs[7]; vecs[9].idWe = 0; vecs[9].expStall = 0;
    // 10..15: forwarding priority and qualifiers
    vecs[10].memValid = 1; vecs[10].memWe = 1; vecs[10].memRd = 3;
    vecs[10].exValid = 1; vecs[10].exRs = rs(3, 3); vecs[10].expFwd = 4'b0101;
    vecs[11] = vecs[10]; vecs[11].wbValid = 1; vecs[11].wbWe = 1; vecs[11].wbRd = 3;
    vecs[12] = vecs[11]; vecs[12].memIsLoad = 1; vecs[12].expFwd = 4'b1010;
    vecs[13].exValid = 1; vecs[13].exRs = rs(2, 6); vecs[13].wbValid = 1; vecs[13].wbWe = 1;
    vecs[13].wbRd = 6; vecs[13].expFwd = 4'b1000;
    vecs[14].memValid = 1; vecs[14].memWe = 1; vecs[14].memRd = 0; vecs[14].exValid = 1;
    vecs[14].exRs = rs(0, 0);
    vecs[15].memValid = 1; vecs[15].memRd = 3; vecs[15].exValid = 1; vecs[15].exRs = rs(3, 0);
    // 16..17: load qualifiers missing
    vecs[16] = vecs[1]; vecs[16].exValid = 0; vecs[16].idRs = rs(5, 0); vecs[16].expStall = 0;
    vecs[17] = vecs[1]; vecs[17].exWe = 0; vecs[17].idRs = rs(5, 0); vecs[17].expStall = 0;
    // 18: MEM on source 0, WB on source 1
    vecs[18].memValid = 1; vecs[18].memWe = 1; vecs[18].memRd = 3; vecs[18].wbValid = 1;
    vecs[18].wbWe = 1; vecs[18].wbRd = 7; vecs[18].exValid = 1; vecs[18].exRs = rs(3, 7);
    vecs[18].expFwd = 4'b1001;
    // 19: decode multiply with an empty multiplier never stalls
    vecs[19].idValid = 1; vecs[19].idIsMul = 1; vecs[19].idWe = 1; vecs[19].idRd = 9;
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    rstN = 0;
    clearInputs();
    buildTable();
    tick();
    tick();

    // Combinational table, applied while reset holds the scoreboard empty.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_fwd", i), 32'(fwdSel), 32'(vecs[i].expFwd));
      checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
      @(negedge clk);
    end
    clearInputs();
    tick();
    checkOutput("reset_pend", pendVec, 32'h0);
    checkOutput("reset_cnt", 32'(outCnt), 32'd0);
    checkOutput("reset_perf", perfStallCnt, 32'd0);
    rstN = 1;

    // Load-use: stall one cycle, then forward the load from WB.
    exValid = 1; exWe = 1; exIsLoad = 1; exRd = 5;
    idValid = 1; idRs = rs(5, 7); idRd = 6; idWe = 1;
    #1 checkOutput("lu_stall", 32'(stall), 32'd1);
    tick();
    exValid = 0; exWe = 0; exIsLoad = 0; exRd = 0;
    memValid = 1; memWe = 1; memIsLoad = 1; memRd = 5;
    #1 checkOutput("lu_bubble_stall", 32'(stall), 32'd0);
    tick();
    clearInputs();
    exValid = 1; exWe = 1; exRs = rs(5, 7); exRd = 6; wbValid = 1; wbWe = 1; wbRd = 5;
    #1 checkOutput("lu_fwd_wb", 32'(fwdSel), 32'b0010);
    tick();
    checkOutput("lu_perf", perfStallCnt, 32'd1);

    // Multiply to x9, user stalls until the done cycle, then forwards from MUL.
    clearInputs();
    exValid = 1; exWe = 1; exIsMul = 1; exRd = 9;
    idValid = 1; idRs = rs(9, 0); idRd = 13; idWe = 1;
    #1 checkOutput("mul_use_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("mul_pend9", pendVec, 32'h0000_0200);
    checkOutput("mul_cnt1", 32'(outCnt), 32'd1);
    exValid = 0; exWe = 0; exIsMul = 0; exRd = 0;
    #1 checkOutput("mul_pending_stall", 32'(stall), 32'd1);
    tick();
    #1 checkOutput("mul_pending_stall2", 32'(stall), 32'd1);
    tick();
    mulDoneValid = 1; mulDoneRd = 9;
    #1 checkOutput("mul_done_no_stall", 32'(stall), 32'd0);
    tick();
    clearInputs();
    exValid = 1; exWe = 1; exRs = rs(9, 0); exRd = 13;
    #1 checkOutput("mul_fwd_mul", 32'(fwdSel), 32'b0011);
    checkOutput("mul_pend_clear", pendVec, 32'h0);
    checkOutput("mul_cnt0", 32'(outCnt), 32'd0);
    tick();
    #1 checkOutput("mulq_one_cycle", 32'(fwdSel), 32'b0000);
    checkOutput("mul_perf", perfStallCnt, 32'd4);

    // Flushed multiply never enters; unflushed one causes WAW until done.
    clearInputs();
    exValid = 1; exWe = 1; exIsMul = 1; exRd = 4; flush = 1;
    tick();
    checkOutput("flush_pend", pendVec, 32'h0);
    checkOutput("flush_cnt", 32'(outCnt), 32'd0);
    flush = 0;
    idValid = 1; idRs = rs(1, 0); idRd = 4; idWe = 1;
    #1 checkOutput("waw_ex_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("waw_pend4", pendVec, 32'h0000_0010);
    exValid = 0; exWe = 0; exIsMul = 0; exRd = 0;
    #1 checkOutput("waw_pend_stall", 32'(stall), 32'd1);
    tick();
    idValid = 0; mulDoneValid = 1; mulDoneRd = 4;
    tick();
    mulDoneValid = 0; mulDoneRd = 0; idValid = 1;
    #1 checkOutput("waw_released", 32'(stall), 32'd0);
    checkOutput("waw_pend_clear", pendVec, 32'h0);
    checkOutput("waw_perf", perfStallCnt, 32'd6);

    // Fill the multiplier, then exercise full, concurrent and overflow cases.
    clearInputs();
    exValid = 1; exWe = 1; exIsMul = 1;
    for (int r = 1; r <= 4; r++) begin
      exRd = 5'(r);
      tick();
    end
    checkOutput("full_cnt4", 32'(outCnt), 32'd4);
    checkOutput("full_pend", pendVec, 32'h0000_001E);
    clearInputs();
    idValid = 1; idIsMul = 1; idWe = 1; idRd = 10; idRs = rs(11, 12);
    #1 checkOutput("full_stall", 32'(stall), 32'd1);
    tick();
    mulDoneValid = 1; mulDoneRd = 1;
    #1 checkOutput("full_done_no_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("full_cnt3", 32'(outCnt), 32'd3);
    clearInputs();
    exValid = 1; exWe = 1; exIsMul = 1; exRd = 10;
    tick();
    checkOutput("full_cnt_back4", 32'(outCnt), 32'd4);
    exRd = 11; mulDoneValid = 1; mulDoneRd = 2;
    tick();
    checkOutput("issue_done_cnt", 32'(outCnt), 32'd4);
    checkOutput("issue_done_pend", pendVec, 32'h0000_0C18);
    exRd = 3; mulDoneRd = 3;
    tick();
    checkOutput("same_reg_pend", pendVec, 32'h0000_0C18);
    checkOutput("same_reg_cnt", 32'(outCnt), 32'd4);
    mulDoneValid = 0; mulDoneRd = 0; exRd = 12;
    tick();
    checkOutput("overflow_cnt", 32'(outCnt), 32'd4);
    checkOutput("overflow_pend", pendVec, 32'h0000_1C18);
    checkOutput("full_perf", perfStallCnt, 32'd7);

    // Reset mid-operation overrides same-cycle issue and done.
    clearInputs();
    rstN = 0;
    exValid = 1; exWe = 1; exIsMul = 1; exRd = 5; mulDoneValid = 1; mulDoneRd = 3;
    tick();
    checkOutput("rst_pend", pendVec, 32'h0);
    checkOutput("rst_cnt", 32'(outCnt), 32'd0);
    checkOutput("rst_perf", perfStallCnt, 32'd0);
    rstN = 1;
    clearInputs();
    exValid = 1; exRs = rs(3, 0);
    #1 checkOutput("rst_mulq_cleared", 32'(fwdSel), 32'b0000);
    mulDoneValid = 1; mulDoneRd = 3;
    tick();
    mulDoneRd = 4;
    tick();
    clearInputs();
    checkOutput("stray_done_cnt", 32'(outCnt), 32'd0);
    checkOutput("stray_done_pend", pendVec, 32'h0);

    // Long stall with the counter preloaded near its ceiling.
    exValid = 1; exWe = 1; exIsLoad = 1; exRd = 5; idValid = 1; idRs = rs(5, 0);
    #1 checkOutput("sat_stall", 32'(stall), 32'd1);
    force dut.perfStallCnt = 32'hFFFF_FFFE;
    tick();
    release dut.perfStallCnt;
    tick();
    tick();
    tick();
    checkOutput("perf_saturate", perfStallCnt, 32'hFFFF_FFFF);

    clearInputs();
    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
